// File: rtl/mesm6_gpio_irq.sv
// GPIO peripheral for the MESM-6 data bus: debounced inputs with rise/fall edge
// interrupts (enable/mask/pending) and NOUT outputs with atomic set/clear.
module mesm6_gpio_irq #(
    parameter int NIN             = 10,
    parameter int NOUT            = 32,
    parameter int DEBOUNCE_CYCLES = 10000,
    parameter int SYNC_STAGES     = 2
) (
    input  logic            clk,
    input  logic            reset,
    input  logic [14:0]     i_addr,
    input  logic            i_read,
    input  logic            i_write,
    input  logic [47:0]     i_data,
    output logic [47:0]     o_data,
    output logic            o_done,
    output logic            o_irq,
    input  logic [NIN-1:0]  i_pins,
    output logic [NOUT-1:0] o_pins
);

    localparam int            CW       = $clog2(DEBOUNCE_CYCLES) + 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

    logic [NIN-1:0]  r_sync [SYNC_STAGES];
    logic [NIN-1:0]  r_stable;
    logic [NIN-1:0]  w_stable_next;
    logic [NIN-1:0]  w_event;
    logic [NOUT-1:0] r_out;
    logic [NOUT-1:0] w_out_next;
    logic [NIN-1:0]  r_mask, r_rise_en, r_fall_en, r_pend;
    logic [NIN-1:0]  w_mask_next, w_rise_en_next, w_fall_en_next, w_pend_next;
    logic [NIN-1:0]  w_w1c;
    logic [47:0]     w_rdata;
    logic [2:0]      w_sel;

    assign w_sel  = i_addr[2:0];
    assign o_pins = r_out;

    genvar gi;
    generate
        for (gi = 0; gi < SYNC_STAGES; gi++) begin : g_sync
            always_ff @(posedge clk) begin
                if (!reset)
                    r_sync[gi] <= '0;
                else if (gi == 0)
                    r_sync[gi] <= i_pins;
                else
                    r_sync[gi] <= r_sync[(gi == 0) ? 0 : gi - 1];
            end
        end

        for (gi = 0; gi < NIN; gi++) begin : g_deb
            logic          w_s;
            logic [CW-1:0] r_cnt;

            assign w_s = r_sync[SYNC_STAGES-1][gi];

            // The counter only runs while the synchronised input disagrees with
            // the accepted value, so any shorter glitch resets it to zero.
            always_ff @(posedge clk) begin
                if (!reset)
                    r_cnt <= '0;
                else if (w_s == r_stable[gi] || r_cnt == CNT_LAST)
                    r_cnt <= '0;
                else
                    r_cnt <= r_cnt + CW'(1);
            end

            assign w_stable_next[gi] = (w_s != r_stable[gi] && r_cnt == CNT_LAST) ? w_s : r_stable[gi];
        end
    endgenerate

    assign w_event = (w_stable_next & ~r_stable & r_rise_en)
                   | (~w_stable_next & r_stable & r_fall_en);

    always_comb begin
        w_out_next     = r_out;
        w_mask_next    = r_mask;
        w_rise_en_next = r_rise_en;
        w_fall_en_next = r_fall_en;
        w_w1c          = '0;
        if (i_write) begin
            case (w_sel)
                3'd1: w_out_next     = i_data[NOUT-1:0];
                3'd2: w_out_next     = r_out | i_data[NOUT-1:0];
                3'd3: w_out_next     = r_out & ~i_data[NOUT-1:0];
                3'd4: w_mask_next    = i_data[NIN-1:0];
                3'd5: w_rise_en_next = i_data[NIN-1:0];
                3'd6: w_fall_en_next = i_data[NIN-1:0];
                3'd7: w_w1c          = i_data[NIN-1:0];
                default: ;
            endcase
        end
    end

    // A new event on a bit overrides a clear written in the same cycle.
    assign w_pend_next = (r_pend & ~w_w1c) | w_event;

    always_comb begin
        w_rdata = '0;
        if (i_read && !i_write) begin
            case (w_sel)
                3'd0: w_rdata = 48'(r_stable);
                3'd1: w_rdata = 48'(r_out);
                3'd4: w_rdata = 48'(r_mask);
                3'd5: w_rdata = 48'(r_rise_en);
                3'd6: w_rdata = 48'(r_fall_en);
                3'd7: w_rdata = 48'(r_pend);
                default: w_rdata = '0;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            r_stable  <= '0;
            r_out     <= '0;
            r_mask    <= '0;
            r_rise_en <= '0;
            r_fall_en <= '0;
            r_pend    <= '0;
            o_irq     <= 1'b0;
            o_done    <= 1'b0;
            o_data    <= '0;
        end else begin
            r_stable  <= w_stable_next;
            r_out     <= w_out_next;
            r_mask    <= w_mask_next;
            r_rise_en <= w_rise_en_next;
            r_fall_en <= w_fall_en_next;
            r_pend    <= w_pend_next;
            o_irq     <= |(w_pend_next & w_mask_next);
            o_done    <= i_read | i_write;
            o_data    <= w_rdata;
        end
    end

endmodule

// File: tb/tb_mesm6_gpio_irq.sv
// Scoreboard bench for mesm6_gpio_irq: expected read data queued at request time,
// popped and compared when o_done appears; o_done timing checked every cycle.
module tb_mesm6_gpio_irq;

    localparam int NIN  = 10;
    localparam int NOUT = 32;
    localparam int DEB  = 4;
    localparam int SYNC = 2;

    logic            clk     = 1'b0;
    logic            reset   = 1'b0;
    logic [14:0]     i_addr  = '0;
    logic            i_read  = 1'b0;
    logic            i_write = 1'b0;
    logic [47:0]     i_data  = '0;
    logic [47:0]     o_data;
    logic            o_done;
    logic            o_irq;
    logic [NIN-1:0]  i_pins  = '0;
    logic [NOUT-1:0] o_pins;

    mesm6_gpio_irq #(
        .NIN(NIN), .NOUT(NOUT), .DEBOUNCE_CYCLES(DEB), .SYNC_STAGES(SYNC)
    ) dut (
        .clk(clk), .reset(reset), .i_addr(i_addr), .i_read(i_read),
        .i_write(i_write), .i_data(i_data), .o_data(o_data), .o_done(o_done),
        .o_irq(o_irq), .i_pins(i_pins), .o_pins(o_pins)
    );

    always #5 clk = ~clk;

    typedef struct {
        bit          chk;
        logic [47:0] exp;
        string       tag;
    } sb_t;

    sb_t sb_q[$];
    int  n_checks = 0;
    int  n_errors = 0;
    bit  req_prev = 1'b0;

    task automatic check_eq(input string tag, input logic [47:0] got, input logic [47:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got=0x%0h expected=0x%0h", tag, got, exp);
        end
    endtask

    task automatic bus(input bit rd, input bit wr, input logic [2:0] a,
                       input logic [47:0] d, input logic [47:0] exp, input string tag);
        sb_t e;
        e.chk = rd;
        e.exp = exp;
        e.tag = tag;
        sb_q.push_back(e);
        i_read  = rd;
        i_write = wr;
        i_addr  = {12'h000, a};
        i_data  = d;
        @(negedge clk);
        i_read  = 1'b0;
        i_write = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    always @(posedge clk) req_prev <= (i_read | i_write) & reset;

    always @(negedge clk) begin
        sb_t e;
        check_eq("done_timing", 48'(o_done), 48'(req_prev));
        if (o_done) begin
            if (sb_q.size() == 0) begin
                check_eq("sb_underflow", 48'(sb_q.size()), 48'd1);
            end else begin
                e = sb_q.pop_front();
                if (e.chk)
                    check_eq(e.tag, o_data, e.exp);
                $display("txn %s data=0x%0h", e.tag, o_data);
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        reset  = 1'b0;
        i_pins = '1;
        repeat (3) begin
            @(negedge clk);
            check_eq("rst_o_pins", 48'(o_pins), 48'h0);
            check_eq("rst_o_irq", 48'(o_irq), 48'h0);
            check_eq("rst_o_done", 48'(o_done), 48'h0);
        end
        reset = 1'b1;
        // Stable flips on the SYNC+DEB-th edge after release; reads sample the pre-edge value.
        for (int k = 1; k <= 8; k++)
            bus(1, 0, 3'd0, '0, (k >= SYNC + DEB + 1) ? 48'h3FF : 48'h0, "in_after_reset");

        i_pins = '0;
        idle(10);

        bus(0, 1, 3'd1, 48'h12345678, '0, "wr_out");
        bus(0, 1, 3'd2, 48'h0000000F, '0, "wr_out_set");
        bus(0, 1, 3'd3, 48'h10000000, '0, "wr_out_clr");
        check_eq("o_pins_setclr", 48'(o_pins), 48'h0234567F);
        bus(1, 0, 3'd1, '0, 48'h0234567F, "rd_out");
        bus(1, 0, 3'd2, '0, 48'h0, "rd_out_set");

        bus(0, 1, 3'd5, 48'h008, '0, "wr_rise_en");
        i_pins[3] = 1'b1;
        idle(DEB - 1);
        i_pins[3] = 1'b0;
        idle(8);
        bus(1, 0, 3'd0, '0, 48'h0, "rd_in_glitch");
        bus(1, 0, 3'd7, '0, 48'h0, "rd_pend_glitch");

        i_pins[3] = 1'b1;
        for (int k = 1; k <= 8; k++)
            bus(1, 0, 3'd0, '0, (k >= SYNC + DEB + 1) ? 48'h008 : 48'h0, "in_rise3");
        bus(1, 0, 3'd7, '0, 48'h008, "rd_pend_rise3");
        check_eq("irq_masked", 48'(o_irq), 48'h0);

        bus(0, 1, 3'd6, 48'h001, '0, "wr_fall_en");
        bus(0, 1, 3'd4, 48'h001, '0, "wr_mask");
        i_pins[0] = 1'b1;
        idle(10);
        check_eq("irq_rise0_noen", 48'(o_irq), 48'h0);
        bus(1, 0, 3'd7, '0, 48'h008, "rd_pend_rise0");

        i_pins[0] = 1'b0;
        idle(SYNC + DEB - 1);
        check_eq("irq_before_fall", 48'(o_irq), 48'h0);
        idle(1);
        check_eq("irq_after_fall", 48'(o_irq), 48'h1);
        bus(1, 0, 3'd7, '0, 48'h009, "rd_pend_fall0");

        bus(0, 1, 3'd7, 48'h001, '0, "w1c_pend0");
        check_eq("irq_after_w1c", 48'(o_irq), 48'h0);
        bus(1, 0, 3'd7, '0, 48'h008, "rd_pend_w1c");

        i_pins[0] = 1'b1;
        idle(10);
        i_pins[0] = 1'b0;
        idle(SYNC + DEB - 1);
        bus(0, 1, 3'd7, 48'h001, '0, "w1c_collide");
        check_eq("irq_collide", 48'(o_irq), 48'h1);
        bus(1, 0, 3'd7, '0, 48'h009, "rd_pend_collide");

        bus(1, 1, 3'd4, 48'h3, 48'h0, "rdwr_mask");
        bus(1, 0, 3'd4, '0, 48'h3, "rd_mask");

        i_read = 1'b1;
        i_addr = 15'd4;
        reset  = 1'b0;
        @(negedge clk);
        check_eq("rst_mid_done", 48'(o_done), 48'h0);
        i_read = 1'b0;
        check_eq("rst_mid_irq", 48'(o_irq), 48'h0);
        check_eq("rst_mid_pins", 48'(o_pins), 48'h0);
        reset = 1'b1;
        bus(1, 0, 3'd4, '0, 48'h0, "rd_mask_after_rst");
        bus(1, 0, 3'd7, '0, 48'h0, "rd_pend_after_rst");
        idle(2);
        check_eq("sb_empty", 48'(sb_q.size()), 48'h0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
